// File: rtl/hamming_argmin.sv
// Streaming nearest-class search: accumulates per-class Hamming distance
// chunk by chunk and reports the index of the closest class.
module hamming_argmin #(
    parameter int DW     = 8,
    parameter int NCHUNK = 4,
    parameter int NCLASS = 4,
    localparam int DISTW = $clog2(DW * NCHUNK + 1),
    localparam int CW    = $clog2(NCLASS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_query,
    input  logic [DW-1:0]    s_class,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CW-1:0]    m_idx,
    output logic [DISTW-1:0] m_dist
);

    localparam int PW = $clog2(DW + 1);
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] LASTK = KW'(NCHUNK - 1);
    localparam logic [CW-1:0] LASTC = CW'(NCLASS - 1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t            state_q, state_d;
    logic              live_q;
    logic [KW-1:0]     chunk_q;
    logic [CW-1:0]     cls_q;
    logic [DISTW-1:0]  acc_q;
    logic [DISTW-1:0]  best_dist_q;
    logic [CW-1:0]     best_idx_q;

    logic              beat;
    logic              last_chunk;
    logic              last_beat;
    logic [PW-1:0]     pc;
    logic [DISTW-1:0]  class_dist;

    function automatic logic [PW-1:0] popcnt(input logic [DW-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < DW; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    assign pc         = popcnt(s_query ^ s_class);
    assign class_dist = ((chunk_q == '0) ? '0 : acc_q) + DISTW'(pc);
    assign beat       = s_valid && s_ready;
    assign last_chunk = (chunk_q == LASTK);
    assign last_beat  = last_chunk && (cls_q == LASTC);

    // live_q keeps s_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            ACCUM: begin
                s_ready = live_q;
                if (beat && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
        if (clr) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chunk_q <= '0;
            cls_q   <= '0;
            acc_q   <= '0;
        end else if (clr) begin
            chunk_q <= '0;
            cls_q   <= '0;
            acc_q   <= '0;
        end else if (beat) begin
            acc_q <= class_dist;
            if (last_chunk) begin
                chunk_q <= '0;
                cls_q   <= last_beat ? '0 : cls_q + CW'(1);
            end else begin
                chunk_q <= chunk_q + KW'(1);
            end
        end else if (m_valid && m_ready) begin
            chunk_q <= '0;
            cls_q   <= '0;
        end
    end

    // Strict less-than keeps the lower index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_dist_q <= '0;
            best_idx_q  <= '0;
        end else if (!clr && beat && last_chunk) begin
            if (cls_q == '0 || class_dist < best_dist_q) begin
                best_dist_q <= class_dist;
                best_idx_q  <= cls_q;
            end
        end
    end

    assign m_idx  = best_idx_q;
    assign m_dist = best_dist_q;

endmodule

// File: tb/tb_hamming_argmin.sv
// Directed bench for hamming_argmin with DW=8, NCHUNK=2, NCLASS=3.
module tb_hamming_argmin;

    logic       clk;
    logic       rst_n;
    logic       clr;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_query;
    logic [7:0] s_class;
    logic       m_valid;
    logic       m_ready;
    logic [1:0] m_idx;
    logic [4:0] m_dist;

    int checks;
    int failures;

    hamming_argmin #(.DW(8), .NCHUNK(2), .NCLASS(3)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_query(s_query), .s_class(s_class),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_idx(m_idx), .m_dist(m_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Six class-major beats; cls/gaps read left to right, query chunks q0,q1
    task automatic run_search(input logic [7:0] q0, input logic [7:0] q1,
                              input logic [47:0] cls, input logic [23:0] gaps);
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b0;
            repeat (int'(gaps[23-4*i -: 4])) begin
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_query = (i % 2 == 1) ? q1 : q0;
            s_class = cls[47-8*i -: 8];
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_s_ready got %b want 0", s_ready);
        end
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_m_valid got %b want 0", m_valid);
        end
        checks++;
        if (m_idx !== 2'd0 || m_dist !== 5'd0) begin
            failures++;
            $display("FAIL rst_out got idx=%0d dist=%0d want 0 0", m_idx, m_dist);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready_early got %b want 0", s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_first_edge got %b want 1", s_ready);
        end
    endtask

    task automatic test_basic;
        run_search(8'hFF, 8'h00, 48'h0F_00_FF_01_00_FF, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_latency got mv=%b rdy=%b want 1 0", m_valid, s_ready);
        end
        checks++;
        if (m_idx !== 2'd1 || m_dist !== 5'd1) begin
            failures++;
            $display("FAIL basic_result got idx=%0d dist=%0d want 1 1", m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_handshake got mv=%b rdy=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_tie;
        run_search(8'hFF, 8'h00, 48'h1F_00_07_00_FF_07, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd0 || m_dist !== 5'd3) begin
            failures++;
            $display("FAIL tie got mv=%b idx=%0d dist=%0d want 1 0 3", m_valid, m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_last_wins;
        run_search(8'hFF, 8'h00, 48'h00_FF_00_FF_FE_00, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd2 || m_dist !== 5'd1) begin
            failures++;
            $display("FAIL last_wins got mv=%b idx=%0d dist=%0d want 1 2 1", m_valid, m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        run_search(8'hFF, 8'h00, 48'h0F_00_FF_01_00_FF, 24'h0);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_query = 8'hA5;
            s_class = 8'h5A;
            @(posedge clk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d] got mv=%b rdy=%b want 1 0", i, m_valid, s_ready);
            end
            checks++;
            if (m_idx !== 2'd1 || m_dist !== 5'd1) begin
                failures++;
                $display("FAIL bp_stable[%0d] got idx=%0d dist=%0d want 1 1", i, m_idx, m_dist);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got rdy=%b mv=%b want 1 0", s_ready, m_valid);
        end
        run_search(8'hFF, 8'h00, 48'h1F_00_07_00_FF_07, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd0 || m_dist !== 5'd3) begin
            failures++;
            $display("FAIL bp_no_consume got mv=%b idx=%0d dist=%0d want 1 0 3", m_valid, m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_gaps;
        run_search(8'hFF, 8'h00, 48'h0F_00_FF_01_00_FF, 24'h203102);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd1 || m_dist !== 5'd1) begin
            failures++;
            $display("FAIL gaps got mv=%b idx=%0d dist=%0d want 1 1 1", m_valid, m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    task automatic test_clr;
        s_valid = 1'b1;
        s_query = 8'hFF;
        s_class = 8'h00;
        @(posedge clk);
        #1;
        s_query = 8'h00;
        s_class = 8'hFF;
        @(posedge clk);
        #1;
        clr = 1'b1;
        s_query = 8'hFF;
        s_class = 8'h00;
        @(posedge clk);
        #1;
        clr = 1'b0;
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL clr_abort got rdy=%b mv=%b want 1 0", s_ready, m_valid);
        end
        run_search(8'hFF, 8'h00, 48'h0F_00_FF_01_00_FF, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd1 || m_dist !== 5'd1) begin
            failures++;
            $display("FAIL clr_fresh got mv=%b idx=%0d dist=%0d want 1 1 1", m_valid, m_idx, m_dist);
        end
        clr = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_done got mv=%b rdy=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_async_reset;
        s_valid = 1'b1;
        s_query = 8'hFF;
        s_class = 8'h00;
        @(posedge clk);
        #1;
        s_query = 8'h00;
        s_class = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (m_dist !== 5'd16 || m_idx !== 2'd0) begin
            failures++;
            $display("FAIL ar_class0 got idx=%0d dist=%0d want 0 16", m_idx, m_dist);
        end
        s_query = 8'hFF;
        s_class = 8'h00;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_dist !== 5'd0 || m_idx !== 2'd0) begin
            failures++;
            $display("FAIL ar_outputs got idx=%0d dist=%0d want 0 0", m_idx, m_dist);
        end
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL ar_handshake got rdy=%b mv=%b want 0 0", s_ready, m_valid);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ar_ready got %b want 1", s_ready);
        end
        run_search(8'hFF, 8'h00, 48'h00_FF_00_FF_00_FF, 24'h0);
        checks++;
        if (m_valid !== 1'b1 || m_idx !== 2'd0 || m_dist !== 5'd16) begin
            failures++;
            $display("FAIL ar_full got mv=%b idx=%0d dist=%0d want 1 0 16", m_valid, m_idx, m_dist);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        s_valid  = 1'b0;
        s_query  = 8'h00;
        s_class  = 8'h00;
        m_ready  = 1'b0;
        test_reset();
        test_basic();
        test_tie();
        test_last_wins();
        test_backpressure();
        test_gaps();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
